// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM-stage load/store sequencer with lane alignment, stall and branch redirect.
// Optional MEM_MISALIGN_CHECK_EN adds misalign_out and suppresses misaligned requests.
module mem_stage_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [7:0]        dmem_req_strb,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              stall_out,
  output logic              load_valid_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              pc_redirect_out
`ifdef MEM_MISALIGN_CHECK_EN
  , output logic            misalign_out
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic [2:0] off_q;
  logic [1:0] size_q;
  logic uns_q;
  logic op;
  logic [2:0] off;
  logic [7:0] base, strb_n;
  logic [DATA_W-1:0] wdata_n, shifted, ext;
  assign op = mem_read_in | mem_write_in;
  assign off = addr_in[2:0];
  assign base = size_in == 2'b00 ? 8'h01 : size_in == 2'b01 ? 8'h03 : 8'h0F;
  assign strb_n = size_in == 2'b11 ? 8'hFF : base << off;
  assign wdata_n = wdata_in << {off, 3'b000};
  assign shifted = dmem_resp_rdata >> {off_q, 3'b000};
  assign ext = size_q == 2'b00 ? {{56{~uns_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'b01 ? {{48{~uns_q & shifted[15]}}, shifted[15:0]} :
               size_q == 2'b10 ? {{32{~uns_q & shifted[31]}}, shifted[31:0]} : shifted;
  assign dmem_req_valid = state == REQ;
  assign stall_out = (state == IDLE && op) || state == REQ || state == WAIT;
  assign pc_redirect_out = branch_in & ~stall_out;
`ifdef MEM_MISALIGN_CHECK_EN
  logic mis;
  assign mis = (size_in == 2'b01 && off[0]) || (size_in == 2'b10 && |off[1:0]) ||
               (size_in == 2'b11 && |off);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      dmem_req_we <= 1'b0;
      dmem_req_addr <= '0;
      dmem_req_wdata <= '0;
      dmem_req_strb <= '0;
      load_valid_out <= 1'b0;
      load_data_out <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (op) begin
          off_q <= off;
          size_q <= size_in;
          uns_q <= unsigned_in;
          dmem_req_we <= mem_write_in & ~mem_read_in;
          dmem_req_addr <= {addr_in[ADDR_W-1:3], 3'b000};
          dmem_req_wdata <= wdata_n;
          dmem_req_strb <= strb_n;
          state <= REQ;
`ifdef MEM_MISALIGN_CHECK_EN
          if (mis) begin
            state <= DONE;
            misalign_out <= 1'b1;
          end
`endif
        end
        REQ: if (dmem_req_ready) state <= dmem_req_we ? DONE : WAIT;
        WAIT: if (dmem_resp_valid) begin
          load_data_out <= ext;
          load_valid_out <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          load_valid_out <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_out <= 1'b0;
`endif
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb_mem_stage_access_unit: directed checks of load/store sequencing, lane math, stall and redirect.
module tb_mem_stage_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, unsigned_in = 1'b0;
  logic [63:0] addr_in = '0, wdata_in = '0, dmem_resp_rdata = '0;
  logic [1:0] size_in = '0;
  logic dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
  logic dmem_req_valid, dmem_req_we, stall_out, load_valid_out, pc_redirect_out;
  logic [63:0] dmem_req_addr, dmem_req_wdata, load_data_out;
  logic [7:0] dmem_req_strb;
  int total = 0, passed = 0, accepts = 0, acc0;
`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_out;
`endif
  always #5 clk = ~clk;
  mem_stage_access_unit dut (
    .clk(clk), .reset(reset), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .addr_in(addr_in), .wdata_in(wdata_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_strb(dmem_req_strb), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_rdata(dmem_resp_rdata), .stall_out(stall_out), .load_valid_out(load_valid_out),
    .load_data_out(load_data_out), .pc_redirect_out(pc_redirect_out)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_out(misalign_out)
`endif
  );
  always @(posedge clk) if (!reset && dmem_req_valid && dmem_req_ready) accepts++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, dmem_req_valid, 0);
    chk({tag, "_we"}, dmem_req_we, 0);
    chk({tag, "_addr"}, dmem_req_addr, 0);
    chk({tag, "_wdata"}, dmem_req_wdata, 0);
    chk({tag, "_strb"}, dmem_req_strb, 0);
    chk({tag, "_stall"}, stall_out, 0);
    chk({tag, "_lv"}, load_valid_out, 0);
    chk({tag, "_ld"}, load_data_out, 0);
    chk({tag, "_redir"}, pc_redirect_out, 0);
  endtask
  initial begin
    repeat (2) tick();
    all_zero("rst");
    reset = 1'b0;
    // load byte, sign-extended, ready immediately, response one cycle later
    mem_read_in = 1; addr_in = 64'h1003; size_in = 0; unsigned_in = 0; dmem_req_ready = 1;
    #1 chk("lb_t0_stall", stall_out, 1);
    tick();
    chk("lb_t1_valid", dmem_req_valid, 1);
    chk("lb_t1_addr", dmem_req_addr, 64'h1000);
    chk("lb_t1_strb", dmem_req_strb, 8'h08);
    chk("lb_t1_we", dmem_req_we, 0);
    chk("lb_t1_stall", stall_out, 1);
    tick();
    chk("lb_t2_valid", dmem_req_valid, 0);
    chk("lb_t2_stall", stall_out, 1);
    dmem_resp_valid = 1; dmem_resp_rdata = 64'h00000000_80000000;
    tick();
    dmem_resp_valid = 0; mem_read_in = 0;
    chk("lb_t3_lv", load_valid_out, 1);
    chk("lb_t3_data", load_data_out, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_t3_stall", stall_out, 0);
    tick();
    chk("lb_t4_lv", load_valid_out, 0);
    chk("lb_t4_hold", load_data_out, 64'hFFFFFFFF_FFFFFF80);
    // store half to lanes 6..7
    mem_write_in = 1; addr_in = 64'h2006; size_in = 1; wdata_in = 64'hABCD;
    tick();
    chk("sh_we", dmem_req_we, 1);
    chk("sh_valid", dmem_req_valid, 1);
    chk("sh_strb", dmem_req_strb, 8'hC0);
    chk("sh_wdata", dmem_req_wdata, 64'hABCD0000_00000000);
    chk("sh_addr", dmem_req_addr, 64'h2000);
    tick();
    mem_write_in = 0;
    chk("sh_done_valid", dmem_req_valid, 0);
    chk("sh_done_stall", stall_out, 0);
    chk("sh_done_lv", load_valid_out, 0);
    tick();
    chk("sh_idle_lv", load_valid_out, 0);
    // load word with ready held low for three REQ cycles
    dmem_req_ready = 0; acc0 = accepts;
    mem_read_in = 1; addr_in = 64'h4004; size_in = 2; unsigned_in = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_valid", dmem_req_valid, 1);
      chk("lw_addr", dmem_req_addr, 64'h4000);
      chk("lw_strb", dmem_req_strb, 8'hF0);
      chk("lw_stall", stall_out, 1);
      if (i == 2) dmem_req_ready = 1;
      tick();
    end
    chk("lw_wait_valid", dmem_req_valid, 0);
    chk("lw_wait_stall", stall_out, 1);
    dmem_resp_valid = 1; dmem_resp_rdata = 64'h8899AABB_55667788;
    tick();
    dmem_resp_valid = 0; mem_read_in = 0;
    chk("lw_lv", load_valid_out, 1);
    chk("lw_data", load_data_out, 64'hFFFFFFFF_8899AABB);
    chk("lw_accepts", accepts - acc0, 1);
    tick();
    // unsigned half at offset 6
    mem_read_in = 1; addr_in = 64'h5006; size_in = 1; unsigned_in = 1;
    tick();
    chk("lhu_strb", dmem_req_strb, 8'hC0);
    tick();
    dmem_resp_valid = 1; dmem_resp_rdata = 64'hF00D0000_00000000;
    tick();
    dmem_resp_valid = 0; mem_read_in = 0;
    chk("lhu_data", load_data_out, 64'h00000000_0000F00D);
    tick();
    // dword store
    mem_write_in = 1; addr_in = 64'h6000; size_in = 3; wdata_in = 64'h01234567_89ABCDEF;
    tick();
    chk("sd_strb", dmem_req_strb, 8'hFF);
    chk("sd_wdata", dmem_req_wdata, 64'h01234567_89ABCDEF);
    tick();
    mem_write_in = 0;
    tick();
    // reset in WAIT, late response ignored
    mem_read_in = 1; addr_in = 64'h7000; size_in = 3; unsigned_in = 0;
    tick();
    tick();
    chk("rw_wait_stall", stall_out, 1);
    reset = 1; mem_read_in = 0;
    tick();
    reset = 0;
    dmem_resp_valid = 1; dmem_resp_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    dmem_resp_valid = 0;
    all_zero("rw");
    tick();
    chk("rw_lv_late", load_valid_out, 0);
    // branch redirect with and without a stall
    branch_in = 1;
    #1 chk("br_free", pc_redirect_out, 1);
    mem_read_in = 1; addr_in = 64'h8000; size_in = 3;
    #1 chk("br_idle_stall", pc_redirect_out, 0);
    tick();
    chk("br_req", pc_redirect_out, 0);
    tick();
    dmem_resp_valid = 1;
    tick();
    dmem_resp_valid = 0; mem_read_in = 0;
    chk("br_done", pc_redirect_out, 1);
    branch_in = 0;
    tick();
`ifdef MEM_MISALIGN_CHECK_EN
    acc0 = accepts;
    mem_read_in = 1; addr_in = 64'h3002; size_in = 2;
    #1 chk("mis_stall", stall_out, 1);
    tick();
    mem_read_in = 0;
    chk("mis_valid", dmem_req_valid, 0);
    chk("mis_flag", misalign_out, 1);
    chk("mis_lv", load_valid_out, 0);
    tick();
    chk("mis_clear", misalign_out, 0);
    chk("mis_accepts", accepts - acc0, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
